// File: rtl/rgb_button_conditioner.sv
// Conditions three bouncy RGB push-buttons into single-cycle step pulses with auto-repeat,
// and debounces the foreground/background select switch into a clean level.
module rgb_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 125000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 3125000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btnRaw,
  input  logic       modeRaw,
  output logic [2:0] rgbEn,
  output logic       enable
);

  localparam logic [CNT_W-1:0] DbLast     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               RepeatOn   = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} ch_state_e;

  logic [2:0]       btn_s1_q, btn_s2_q;
  logic             mode_s1_q, mode_s2_q;

  ch_state_e        state_q   [3];
  ch_state_e        state_d   [3];
  logic [CNT_W-1:0] db_cnt_q  [3];
  logic [CNT_W-1:0] db_cnt_d  [3];
  logic [CNT_W-1:0] rep_cnt_q [3];
  logic [CNT_W-1:0] rep_cnt_d [3];
  // Set while waiting out the initial delay, cleared once into periodic repeats.
  logic [2:0]       rep_first_q, rep_first_d;
  logic [2:0]       rgb_en_q, rgb_en_d;

  logic [CNT_W-1:0] mode_cnt_q, mode_cnt_d;
  logic             enable_q, enable_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      mode_s1_q   <= 1'b0;
      mode_s2_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i]   <= StIdle;
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
      end
      rep_first_q <= '0;
      rgb_en_q    <= '0;
      mode_cnt_q  <= '0;
      enable_q    <= 1'b0;
    end else begin
      btn_s1_q    <= btnRaw;
      btn_s2_q    <= btn_s1_q;
      mode_s1_q   <= modeRaw;
      mode_s2_q   <= mode_s1_q;
      for (int i = 0; i < 3; i++) begin
        state_q[i]   <= state_d[i];
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
      rep_first_q <= rep_first_d;
      rgb_en_q    <= rgb_en_d;
      mode_cnt_q  <= mode_cnt_d;
      enable_q    <= enable_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rgb_en_d    = '0;
    for (int i = 0; i < 3; i++) begin
      unique case (state_q[i])
        StIdle: begin
          if (btn_s2_q[i]) begin
            state_d[i]  = StPressDb;
            db_cnt_d[i] = '0;
          end
        end
        StPressDb: begin
          if (!btn_s2_q[i]) begin
            state_d[i] = StIdle;
          end else if (db_cnt_q[i] == DbLast) begin
            state_d[i]     = StHeld;
            rgb_en_d[i]    = 1'b1;
            rep_cnt_d[i]   = '0;
            rep_first_d[i] = 1'b1;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
          end
        end
        StHeld: begin
          if (!btn_s2_q[i]) begin
            state_d[i]  = StRelDb;
            db_cnt_d[i] = '0;
          end else if (RepeatOn) begin
            if (rep_cnt_q[i] == (rep_first_q[i] ? DelayLast : PeriodLast)) begin
              rgb_en_d[i]    = 1'b1;
              rep_cnt_d[i]   = '0;
              rep_first_d[i] = 1'b0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
            end
          end
        end
        StRelDb: begin
          if (btn_s2_q[i]) begin
            // Bounce on release: resume holding with a fresh repeat schedule.
            state_d[i]     = StHeld;
            rep_cnt_d[i]   = '0;
            rep_first_d[i] = 1'b1;
          end else if (db_cnt_q[i] == DbLast) begin
            state_d[i] = StIdle;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    mode_cnt_d = '0;
    enable_d   = enable_q;
    if (mode_s2_q != enable_q) begin
      if (mode_cnt_q == DbLast) begin
        enable_d = mode_s2_q;
      end else begin
        mode_cnt_d = mode_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rgbEn  = rgb_en_q;
  assign enable = enable_q;

endmodule

// File: tb/tb_rgb_button_conditioner.sv
// Scoreboard bench: drivers queue expected pulse/enable events with their edge number,
// a negedge monitor pops and compares whenever the DUT shows a pulse or an enable change.
module tb_rgb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] btnRaw = 3'b111;
  logic       modeRaw = 1'b1;
  logic [2:0] rgbEn;
  logic       enable;

  rgb_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3),
    .CNT_W          (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btnRaw (btnRaw),
    .modeRaw(modeRaw),
    .rgbEn  (rgbEn),
    .enable (enable)
  );

  always #5 clk = ~clk;

  // Number of the most recent rising edge, as seen from the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [2:0] val;
  } ev_t;

  ev_t pulse_q[$];
  ev_t mode_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_ev(input string name, input logic [2:0] act, input ev_t e);
    vectors++;
    if (cyc != e.at || act !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
               name, act, cyc, e.val, e.at);
    end
  endtask

  task automatic unexpected(input string name, input logic [2:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected %b at cycle %0d, expected no event", name, act, cyc);
  endtask

  task automatic push_pulse(input int at, input logic [2:0] val);
    ev_t e;
    e.at  = at;
    e.val = val;
    pulse_q.push_back(e);
  endtask

  task automatic push_mode(input int at, input logic val);
    ev_t e;
    e.at  = at;
    e.val = {2'b00, val};
    mode_q.push_back(e);
  endtask

  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rgbEn !== 3'b000) begin
        if (pulse_q.size() == 0) unexpected("pulse", rgbEn);
        else check_ev("pulse", rgbEn, pulse_q.pop_front());
      end
      if (enable !== prev_en) begin
        if (mode_q.size() == 0) unexpected("enable", {2'b00, enable});
        else check_ev("enable", {2'b00, enable}, mode_q.pop_front());
      end
      prev_en <= enable;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset for edges 1..3 with every raw input high.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_rgb", rgbEn, 3'b000);
      check("reset_en", {2'b00, enable}, 3'b000);
    end
    reset = 1'b1;
    n = cyc + 1;
    push_mode(n + 5, 1'b1);
    push_pulse(n + 6, 3'b111);
    @(negedge clk);
    check("post_reset_rgb", rgbEn, 3'b000);
    check("post_reset_en", {2'b00, enable}, 3'b000);
    wait_until(n + 6);
    btnRaw = 3'b000;
    idle(10);

    // Red held: initial pulse, delayed first repeat, then periodic repeats.
    n = cyc + 1;
    btnRaw = 3'b001;
    push_pulse(n + 6, 3'b001);
    push_pulse(n + 14, 3'b001);
    push_pulse(n + 17, 3'b001);
    push_pulse(n + 20, 3'b001);
    wait_until(n + 20);
    btnRaw = 3'b000;
    idle(12);

    // Green bouncing every 2 cycles never qualifies.
    for (int k = 0; k < 20; k++) begin
      btnRaw = ((k % 4) < 2) ? 3'b010 : 3'b000;
      @(negedge clk);
      check("bounce", rgbEn, 3'b000);
    end
    btnRaw = 3'b000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bounce_tail", rgbEn, 3'b000);
    end

    // Blue held with a 2-cycle release glitch: repeat schedule restarts.
    n = cyc + 1;
    btnRaw = 3'b100;
    push_pulse(n + 6, 3'b100);
    push_pulse(n + 14, 3'b100);
    push_pulse(n + 27, 3'b100);
    wait_until(n + 14);
    btnRaw = 3'b000;
    wait_until(n + 16);
    btnRaw = 3'b100;
    wait_until(n + 27);
    btnRaw = 3'b000;
    idle(12);

    // Mode 1->0, then 0->1, then a 3-cycle glitch that must be ignored.
    n = cyc + 1;
    modeRaw = 1'b0;
    push_mode(n + 5, 1'b0);
    wait_until(n + 8);
    n = cyc + 1;
    modeRaw = 1'b1;
    push_mode(n + 5, 1'b1);
    wait_until(n + 8);
    modeRaw = 1'b0;
    idle(3);
    modeRaw = 1'b1;
    idle(10);
    check("mode_glitch", {2'b00, enable}, 3'b001);

    // Red and blue together while the mode is stable.
    n = cyc + 1;
    btnRaw = 3'b101;
    push_pulse(n + 6, 3'b101);
    wait_until(n + 6);
    btnRaw = 3'b000;
    check("mode_during_pulse", {2'b00, enable}, 3'b001);
    idle(12);

    // Reset in the middle of a green press, button still held afterwards.
    n = cyc + 1;
    btnRaw = 3'b010;
    wait_until(n + 3);
    reset = 1'b0;
    push_mode(n + 4, 1'b0);
    push_mode(n + 11, 1'b1);
    push_pulse(n + 12, 3'b010);
    @(negedge clk);
    check("mid_reset_rgb", rgbEn, 3'b000);
    @(negedge clk);
    check("mid_reset_rgb", rgbEn, 3'b000);
    reset = 1'b1;
    wait_until(n + 12);
    btnRaw = 3'b000;
    idle(12);

    check("pulses_left", 3'(pulse_q.size()), 3'b000);
    check("modes_left", 3'(mode_q.size()), 3'b000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
